// File: rtl/hazard_pkg.sv
// Shared types for the LEGv8 pipeline hazard/forwarding controller.
package hazard_pkg;

  localparam logic [4:0] XZR = 5'd31;

  typedef enum logic [1:0] {
    FWD_REG = 2'd0,
    FWD_EX  = 2'd1,
    FWD_MEM = 2'd2
  } fwd_sel_t;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       regwrite;
    logic       memread;
  } stage_info_t;

endpackage

// File: rtl/hazard_match.sv
// Single slot-vs-source comparator: hit when the slot is live and its rd matches a used source.
module hazard_match
  import hazard_pkg::*;
#(
  parameter int unsigned REG_W = 5
) (
  input  logic             valid_i,
  input  logic             regwrite_i,
  input  logic [REG_W-1:0] rd_i,
  input  logic [REG_W-1:0] src_i,
  input  logic             uses_i,
  output logic             hit_o
);

  logic live;

  // XZR is hardwired zero, so a write to it is never a real producer.
  assign live  = valid_i & regwrite_i & (rd_i != REG_W'(XZR));
  assign hit_o = uses_i & live & (rd_i == src_i);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Tracks EX/MEM destination registers and drives operand forwarding, load-use stall and flush bubbles.
module pipe_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned REG_W = 5,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rn,
  input  logic [REG_W-1:0] id_rm,
  input  logic             id_uses_rn,
  input  logic             id_uses_rm,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_regwrite,
  input  logic             id_memread,
  input  logic             flush,
  output logic             stall,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_count
);

  stage_info_t ex_q, ex_d, mem_q, mem_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic ex_hit_a, ex_hit_b, mem_hit_a, mem_hit_b;
  fwd_sel_t sel_a, sel_b;

  hazard_match #(.REG_W(REG_W)) u_ex_a (
    .valid_i(ex_q.valid), .regwrite_i(ex_q.regwrite), .rd_i(ex_q.rd),
    .src_i(id_rn), .uses_i(id_uses_rn), .hit_o(ex_hit_a)
  );
  hazard_match #(.REG_W(REG_W)) u_ex_b (
    .valid_i(ex_q.valid), .regwrite_i(ex_q.regwrite), .rd_i(ex_q.rd),
    .src_i(id_rm), .uses_i(id_uses_rm), .hit_o(ex_hit_b)
  );
  hazard_match #(.REG_W(REG_W)) u_mem_a (
    .valid_i(mem_q.valid), .regwrite_i(mem_q.regwrite), .rd_i(mem_q.rd),
    .src_i(id_rn), .uses_i(id_uses_rn), .hit_o(mem_hit_a)
  );
  hazard_match #(.REG_W(REG_W)) u_mem_b (
    .valid_i(mem_q.valid), .regwrite_i(mem_q.regwrite), .rd_i(mem_q.rd),
    .src_i(id_rm), .uses_i(id_uses_rm), .hit_o(mem_hit_b)
  );

  always_comb begin
    stall = id_valid & ~flush & ex_q.memread & (ex_hit_a | ex_hit_b);

    // A load in EX has no result yet; it falls through to MEM/regfile and the stall covers it.
    sel_a = FWD_REG;
    if (ex_hit_a && !ex_q.memread) sel_a = FWD_EX;
    else if (mem_hit_a)            sel_a = FWD_MEM;

    sel_b = FWD_REG;
    if (ex_hit_b && !ex_q.memread) sel_b = FWD_EX;
    else if (mem_hit_b)            sel_b = FWD_MEM;

    mem_d = ex_q;
    ex_d  = '0;
    if (id_valid && !stall && !flush) begin
      ex_d.valid    = 1'b1;
      ex_d.rd       = id_rd;
      ex_d.regwrite = id_regwrite;
      ex_d.memread  = id_memread;
    end

    cnt_d = cnt_q;
    if (stall && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ex_q  <= '0;
      mem_q <= '0;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      cnt_q <= cnt_d;
    end
  end

  assign fwd_a       = sel_a;
  assign fwd_b       = sel_b;
  assign stall_count = cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed table-driven bench for pipe_hazard_ctrl, plus a saturating stall-counter sequence.
module tb_pipe_hazard_ctrl;

  localparam int unsigned REG_W = 5;
  localparam int unsigned CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             id_valid;
  logic [REG_W-1:0] id_rn, id_rm, id_rd;
  logic             id_uses_rn, id_uses_rm, id_regwrite, id_memread, flush;
  logic             stall;
  logic [1:0]       fwd_a, fwd_b;
  logic [CNT_W-1:0] stall_count;

  pipe_hazard_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .id_valid(id_valid),
    .id_rn(id_rn), .id_rm(id_rm), .id_uses_rn(id_uses_rn), .id_uses_rm(id_uses_rm),
    .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread), .flush(flush),
    .stall(stall), .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n, v;
    logic [4:0] rn, rm;
    logic       urn, urm;
    logic [4:0] rd;
    logic       rw, mr, fl;
    logic       e_stall;
    logic [1:0] e_fa, e_fb;
    logic [3:0] e_cnt;
  } vec_t;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  vec_t vecs[$];

  function automatic vec_t mk(logic rst_n, logic v, logic [4:0] rn, logic [4:0] rm,
                              logic urn, logic urm, logic [4:0] rd, logic rw, logic mr,
                              logic fl, logic es, logic [1:0] efa, logic [1:0] efb,
                              logic [3:0] ecnt);
    vec_t t;
    t.rst_n = rst_n; t.v = v; t.rn = rn; t.rm = rm; t.urn = urn; t.urm = urm;
    t.rd = rd; t.rw = rw; t.mr = mr; t.fl = fl;
    t.e_stall = es; t.e_fa = efa; t.e_fb = efb; t.e_cnt = ecnt;
    return t;
  endfunction

  task automatic check(input string name, input int unsigned idx,
                       input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic apply(input vec_t t);
    reset_n = t.rst_n; id_valid = t.v; id_rn = t.rn; id_rm = t.rm;
    id_uses_rn = t.urn; id_uses_rm = t.urm; id_rd = t.rd;
    id_regwrite = t.rw; id_memread = t.mr; flush = t.fl;
  endtask

  initial begin
    logic       m_ex_load;
    logic [3:0] m_cnt;
    logic       e_st;

    // Fields: rst_n v rn rm urn urm rd rw mr fl | stall fwd_a fwd_b count
    vecs.push_back(mk(0,1, 5, 5,1,1, 6,1,0,0, 0,0,0,0)); // 0 reset, dependent read
    vecs.push_back(mk(0,1, 5, 5,1,1, 6,1,0,0, 0,0,0,0)); // 1 reset
    vecs.push_back(mk(1,1, 1, 0,1,0, 5,1,1,0, 0,0,0,0)); // 2 LDUR X5
    vecs.push_back(mk(1,1, 5, 2,1,1, 6,1,0,0, 1,0,0,0)); // 3 ADD X6,X5 -> stall
    vecs.push_back(mk(1,1, 5, 2,1,1, 6,1,0,0, 0,2,0,1)); // 4 retry: fwd MEM
    vecs.push_back(mk(1,1, 6, 8,1,1, 7,1,0,0, 0,1,0,1)); // 5 SUB rn=6: fwd EX
    vecs.push_back(mk(1,1, 1, 6,1,1, 9,1,0,0, 0,0,2,1)); // 6 ORR rm=6: fwd MEM
    vecs.push_back(mk(1,1, 1, 2,1,1,31,1,0,0, 0,0,0,1)); // 7 ADD X31
    vecs.push_back(mk(1,1,31,31,1,1,10,1,0,0, 0,0,0,1)); // 8 read X31 twice
    vecs.push_back(mk(1,1, 1, 0,1,0,31,1,1,0, 0,0,0,1)); // 9 LDUR X31
    vecs.push_back(mk(1,1,31,31,1,1,11,1,0,0, 0,0,0,1)); // 10 read X31: no stall
    vecs.push_back(mk(1,1, 1, 2,1,1, 7,1,0,0, 0,0,0,1)); // 11 ADD X7
    vecs.push_back(mk(1,1, 3, 4,1,1, 7,1,0,0, 0,0,0,1)); // 12 ADD X7 again
    vecs.push_back(mk(1,1, 7, 7,1,1,12,1,0,0, 0,1,1,1)); // 13 EX beats MEM
    vecs.push_back(mk(1,1, 1, 0,1,0, 5,1,1,0, 0,0,0,1)); // 14 LDUR X5
    vecs.push_back(mk(1,1, 5, 2,1,1,13,1,0,1, 0,0,0,1)); // 15 load-use + flush
    vecs.push_back(mk(1,1, 5, 2,1,1,14,1,0,0, 0,2,0,1)); // 16 bubble was inserted
    vecs.push_back(mk(1,1,14,14,0,1,15,1,0,0, 0,0,1,1)); // 17 uses_rn gates fwd_a
    vecs.push_back(mk(1,0,15, 0,1,0, 5,1,1,0, 0,1,0,1)); // 18 invalid ID load
    vecs.push_back(mk(1,1, 5, 0,1,0,16,1,0,0, 0,0,0,1)); // 19 invalid did not enter EX
    vecs.push_back(mk(1,1, 1, 0,1,0, 5,1,1,0, 0,0,0,1)); // 20 LDUR X5
    vecs.push_back(mk(0,1, 5, 0,1,0,17,1,0,0, 1,0,0,1)); // 21 stall while reset asserted
    vecs.push_back(mk(1,1, 5, 0,1,0,17,1,0,0, 0,0,0,0)); // 22 stall gone after reset

    apply(vecs[0]);
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      apply(vecs[i]);
      #1;
      check("stall",       i, 16'(stall),       16'(vecs[i].e_stall));
      check("fwd_a",       i, 16'(fwd_a),       16'(vecs[i].e_fa));
      check("fwd_b",       i, 16'(fwd_b),       16'(vecs[i].e_fb));
      check("stall_count", i, 16'(stall_count), 16'(vecs[i].e_cnt));
      @(posedge clk); #1;
    end

    // Back-to-back LDUR X5,[X5]: stalls every other cycle; count must saturate at 15.
    apply(mk(1,1, 5, 0,1,0, 5,1,1,0, 0,0,0,0));
    m_ex_load = 1'b0;
    m_cnt     = 4'd0;
    for (int k = 0; k < 40; k++) begin
      #1;
      e_st = m_ex_load;
      check("sat_stall", 100 + k, 16'(stall),       16'(e_st));
      check("sat_count", 100 + k, 16'(stall_count), 16'(m_cnt));
      if (e_st && m_cnt != 4'hF) m_cnt = m_cnt + 4'd1;
      m_ex_load = !e_st;
      @(posedge clk); #1;
    end
    check("sat_final", 200, 16'(stall_count), 16'd15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
